sha256_msg_sequencer: RTL and testbench

Front-end controller for the SHA-256 compression core (compute_v1_0). It accepts a byte-oriented message as a stream of 32-bit big-endian words and assembles 512-bit blocks. It applies SHA-256 padding: a 0x80 byte, zero fill, and a 64-bit big-endian bit length. It issues each block to the core with a one-cycle tick and the final flag, waits for done, then presents the final digest on a valid/ready output port.

---
 rtl/sha256_msg_sequencer_if.sv | 24 ++
 rtl/sha256_msg_sequencer.sv | 102 ++++++++++
 tb/tb_sha256_msg_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sha256_msg_sequencer_if.sv
// sha256_msg_sequencer_if: message input, compression-core and digest output bundle
interface sha256_msg_sequencer_if;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_nbytes;
    logic [511:0] core_block;
    logic         core_tick;
    logic         core_final;
    logic         core_done;
    logic [255:0] core_digest;
    logic         dig_valid;
    logic         dig_ready;
    logic [255:0] dig_data;
    modport slave (
        input  in_valid, in_data, in_last, in_nbytes, core_done, core_digest, dig_ready,
        output in_ready, core_block, core_tick, core_final, dig_valid, dig_data
    );
    modport master (
        output in_valid, in_data, in_last, in_nbytes, core_done, core_digest, dig_ready,
        input  in_ready, core_block, core_tick, core_final, dig_valid, dig_data
    );
endinterface

// File: rtl/sha256_msg_sequencer.sv
// sha256_msg_sequencer: pads a big-endian word stream into SHA-256 blocks and sequences the compression core
module sha256_msg_sequencer #(
    parameter int LEN_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    sha256_msg_sequencer_if.slave bus,
    output logic                  busy
);
    typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT, PADBLK, OUT} state_t;
    state_t state, state_nx;
    logic [0:15][31:0] blk, fill_blk, pad_blk;
    logic [3:0] widx;
    logic [LEN_W-4:0] cnt, cnt_nx;
    logic [255:0] dig_q;
    logic pend_final, need_pad, defer, done_q;
    logic acc, rise, fits;
    logic [2:0] n;
    logic [5:0] sh;
    logic [6:0] off;
    logic [31:0] lw;
    assign acc = bus.in_valid && bus.in_ready;
    assign rise = bus.core_done && !done_q;
    assign n = (!bus.in_last || bus.in_nbytes > 3'd4) ? 3'd4 : bus.in_nbytes;
    assign sh = {n, 3'b000};
    // block byte offset where the 0x80 terminator lands; 64 means it spills into a new block
    assign off = {1'b0, widx, 2'b00} + {4'b0000, n};
    assign fits = off <= 7'd55;
    assign lw = (bus.in_data & ~(32'hffff_ffff >> sh)) | (32'h8000_0000 >> sh);
    assign cnt_nx = cnt + (LEN_W-3)'(n);
    assign pad_blk = {defer ? 32'h8000_0000 : 32'h0, 416'h0, cnt, 3'b000};
    always_comb begin
        fill_blk = blk;
        for (int w = 0; w < 16; w++) begin
            if (w == int'(widx)) fill_blk[w] = lw;
            else if (bus.in_last && w > int'(widx))
                fill_blk[w] = (w == int'(widx) + 1 && n == 3'd4) ? 32'h8000_0000 : 32'h0;
        end
        if (bus.in_last && fits) {fill_blk[14], fill_blk[15]} = {cnt_nx, 3'b000};
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, FILL: if (acc) state_nx = (bus.in_last || widx == 4'd15) ? ISSUE : FILL;
            ISSUE:      state_nx = WAIT;
            WAIT:       if (rise) state_nx = pend_final ? OUT : need_pad ? PADBLK : FILL;
            PADBLK:     state_nx = ISSUE;
            OUT:        if (bus.dig_ready) state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end
    always_comb begin
        bus.in_ready = rst && (state == IDLE || state == FILL);
        bus.core_tick = state == ISSUE;
        bus.core_final = state == ISSUE && pend_final;
        bus.dig_valid = state == OUT;
        busy = state != IDLE;
    end
    assign bus.core_block = blk;
    assign bus.dig_data = dig_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk <= '0;
            widx <= '0;
            cnt <= '0;
            dig_q <= '0;
            pend_final <= 1'b0;
            need_pad <= 1'b0;
            defer <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= bus.core_done;
            if (acc) begin
                blk <= fill_blk;
                cnt <= cnt_nx;
                widx <= widx + 4'd1;
            end
            if (acc && bus.in_last) begin
                pend_final <= fits;
                need_pad <= !fits;
                defer <= off == 7'd64;
            end
            if (state == WAIT && rise && pend_final) dig_q <= bus.core_digest;
            if (state == PADBLK) begin
                blk <= pad_blk;
                pend_final <= 1'b1;
                need_pad <= 1'b0;
            end
            if (state == OUT && bus.dig_ready) begin
                widx <= '0;
                cnt <= '0;
                pend_final <= 1'b0;
                need_pad <= 1'b0;
                defer <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// tb_sha256_msg_sequencer: directed checks of padding, core handshake, digest backpressure and reset
module tb_sha256_msg_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    sha256_msg_sequencer_if bus ();
    sha256_msg_sequencer #(.LEN_W(64)) dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy));
    always #5 clk = ~clk;

    int total = 0, bad = 0, ticks = 0, dly = 0, viol = 0, cyc = 0, rise_cyc = 0, t0 = 0;
    logic [511:0] blks [0:15];
    logic         fins [0:15];
    logic [255:0] digest = '0;
    logic [447:0] m3 = 448'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071;
    logic [511:0] m4;
    localparam logic [255:0] DG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DG_56 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    assign bus.core_digest = digest;

    always @(posedge clk) cyc++;

    // core stand-in: done falls a few cycles after each tick, so the previous high level overlaps the next WAIT
    always @(negedge clk) begin
        if (!rst) begin
            dly = 0;
            bus.core_done = 1'b0;
        end else begin
            if (!bus.core_tick && bus.core_final) viol++;
            if (dly > 0 && bus.in_ready) viol++;
            if (bus.core_tick) begin
                if (dly > 0) viol++;
                if (ticks < 16) begin
                    blks[ticks] = bus.core_block;
                    fins[ticks] = bus.core_final;
                end
                ticks++;
                dly = 6;
            end else if (dly > 0) begin
                dly--;
                if (dly == 4) bus.core_done = 1'b0;
                if (dly == 0) begin
                    bus.core_done = 1'b1;
                    rise_cyc = cyc;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input int idx, input logic [511:0] exp, input logic fin);
        chk({tag, "_block"}, blks[idx], exp);
        chk({tag, "_final"}, 512'(fins[idx]), 512'(fin));
    endtask

    task automatic send(input logic [31:0] d, input logic l, input logic [2:0] nb);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        bus.in_last = l;
        bus.in_nbytes = nb;
        while (bus.in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (t >= 100) chk("send_timeout", 512'(t), 512'(0));
    endtask

    task automatic finish_msg(input string tag, input logic [255:0] dg, input int hold);
        int t = 0;
        while (bus.dig_valid !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_dig_valid"}, 512'(bus.dig_valid), 512'(1'b1));
        chk({tag, "_dig_latency"}, 512'(cyc - rise_cyc), 512'(1));
        chk({tag, "_dig_data"}, 512'(bus.dig_data), 512'(dg));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold"}, 512'({bus.dig_valid, bus.in_ready, bus.dig_data}), 512'({2'b10, dg}));
        end
        bus.dig_ready = 1'b1;
        @(negedge clk);
        bus.dig_ready = 1'b0;
        chk({tag, "_dig_drop"}, 512'({bus.dig_valid, busy, bus.in_ready}), 512'(3'b001));
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_last = 1'b0;
        bus.in_nbytes = '0;
        bus.dig_ready = 1'b0;
        for (int i = 0; i < 16; i++)
            m4[511 - 32*i -: 32] = {8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3)};
        repeat (2) @(negedge clk);
        chk("rst_ctrl", 512'({bus.in_ready, bus.core_tick, bus.core_final, bus.dig_valid, busy}), 512'(0));
        chk("rst_block", bus.core_block, 512'(0));
        chk("rst_dig", 512'(bus.dig_data), 512'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("idle_ready", 512'({bus.in_ready, busy}), 512'(2'b10));

        t0 = ticks; digest = DG_ABC;
        send(32'h61626300, 1'b1, 3'd3);
        chk("abc_tick_latency", 512'({bus.core_tick, bus.core_final}), 512'(2'b11));
        finish_msg("abc", DG_ABC, 0);
        chk("abc_ticks", 512'(ticks - t0), 512'(1));
        chk_blk("abc", t0, {32'h61626380, 416'h0, 64'h18}, 1'b1);

        t0 = ticks; digest = DG_EMPTY;
        send(32'hdeadbeef, 1'b1, 3'd0);
        finish_msg("empty", DG_EMPTY, 0);
        chk("empty_ticks", 512'(ticks - t0), 512'(1));
        chk_blk("empty", t0, {32'h80000000, 480'h0}, 1'b1);

        t0 = ticks; digest = DG_56;
        for (int i = 0; i < 14; i++) send(m3[447 - 32*i -: 32], i == 13, 3'd4);
        finish_msg("m56", DG_56, 0);
        chk("m56_ticks", 512'(ticks - t0), 512'(2));
        chk_blk("m56_b0", t0, {m3, 32'h80000000, 32'h0}, 1'b0);
        chk_blk("m56_b1", t0 + 1, {448'h0, 64'h1c0}, 1'b1);

        t0 = ticks; digest = {8{32'h5a5a0055}};
        for (int i = 0; i < 13; i++) send(m3[447 - 32*i -: 32], 1'b0, 3'd4);
        send(32'h6e6f7099, 1'b1, 3'd3);
        finish_msg("m55", {8{32'h5a5a0055}}, 0);
        chk("m55_ticks", 512'(ticks - t0), 512'(1));
        chk_blk("m55", t0, {m3[447:32], 32'h6e6f7080, 64'h1b8}, 1'b1);

        t0 = ticks; digest = {8{32'h0f0f0007}};
        send(32'h61626364, 1'b1, 3'd7);
        finish_msg("nb7", {8{32'h0f0f0007}}, 0);
        chk_blk("nb7", t0, {32'h61626364, 32'h80000000, 384'h0, 64'h20}, 1'b1);

        t0 = ticks; digest = {8{32'hc0de0064}};
        for (int i = 0; i < 16; i++) send(m4[511 - 32*i -: 32], i == 15, 3'd4);
        finish_msg("m64", {8{32'hc0de0064}}, 20);
        chk("m64_ticks", 512'(ticks - t0), 512'(2));
        chk_blk("m64_b0", t0, m4, 1'b0);
        chk_blk("m64_b1", t0 + 1, {32'h80000000, 416'h0, 64'h200}, 1'b1);

        digest = DG_ABC;
        send(32'h61626300, 1'b1, 3'd3);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_ctrl", 512'({bus.in_ready, bus.core_tick, bus.core_final, bus.dig_valid, busy}), 512'(0));
        chk("midrst_block", bus.core_block, 512'(0));
        chk("midrst_dig", 512'(bus.dig_data), 512'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst_quiet", 512'({bus.dig_valid, busy, bus.in_ready}), 512'(3'b001));

        t0 = ticks;
        send(32'h61626300, 1'b1, 3'd3);
        finish_msg("abc_again", DG_ABC, 0);
        chk_blk("abc_again", t0, {32'h61626380, 416'h0, 64'h18}, 1'b1);

        chk("protocol_violations", 512'(viol), 512'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
